fifo_rd_adapter: RTL and testbench

FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

---
 rtl/fifo_rd_pkg.sv | 20 ++
 rtl/fifo_rd_skid.sv | 52 +++++
 rtl/fifo_rd_adapter.sv | 101 ++++++++++
 tb/tb_fifo_rd_adapter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and defaults for the FIFO read adapter.
// The optional transfer counter is enabled with the FIFO_RD_STATS_EN macro.
package fifo_rd_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;
    localparam int SKID_DEPTH     = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } rd_state_e;

    // occ + infl - pop < 2, rearranged so the sum never goes negative.
    function automatic logic rd_slot_free(input logic [1:0] occ, input logic infl, input logic pop);
        return ({1'b0, occ} + {2'b00, infl}) < (3'(SKID_DEPTH) + {2'b00, pop});
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer that holds FIFO words until the stream sink accepts them.
// Not part of the FIFO_RD_STATS_EN option; identical in every build.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // The adapter never overfills or underflows; these guards keep the buffer sane regardless.
    assign pop_ok  = pop && (occ != 2'd0);
    assign push_ok = push && ((occ != 2'(SKID_DEPTH)) || pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Converts a FIFO with 1-cycle read latency into a valid/ready stream with graceful drain.
// Define FIFO_RD_STATS_EN to add the xfer_count transfer counter.
//
// state  | meaning
// IDLE   | stopped, no reads, buffer empty
// ACTIVE | issuing reads whenever the buffer has room
// DRAIN  | no new reads; delivering buffered/in-flight words before IDLE
module fifo_rd_adapter
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  xfer_count
`endif
);

    if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_param
        $error("fifo_rd_adapter: DATA_WIDTH and CNT_WIDTH must be at least 1");
    end

    rd_state_e state;
    logic      infl;
    logic      xfer;
    logic [1:0] occ;

    assign m_valid    = (occ != 2'd0);
    assign xfer       = m_valid && m_ready;
    assign fifo_rd_en = (state == ACTIVE) && !fifo_empty && rd_slot_free(occ, infl, xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            infl  <= 1'b0;
        end else begin
            // A read strobed this cycle has its data on fifo_dout next cycle.
            infl <= fifo_rd_en;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!enable) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        state <= ACTIVE;
                    end else if (occ == 2'd0 && !infl) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (infl),
        .push_data (fifo_dout),
        .pop       (xfer),
        .occ       (occ),
        .head_data (m_data)
    );

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (xfer) begin
            xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Self-checking bench for fifo_rd_adapter: FIFO model, in-order scoreboard, scenario table.
// The xfer_count checks are compiled in when FIFO_RD_STATS_EN is defined.
module tb_fifo_rd_adapter;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_dout = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          busy;
`ifdef FIFO_RD_STATS_EN
    logic [CW-1:0] xfer_count;
`endif

    always #5 clk = ~clk;

    fifo_rd_adapter #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .busy       (busy)
`ifdef FIFO_RD_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    // Upstream FIFO model and the expected stream: words leave in the order they are read.
    logic [DW-1:0] fq[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] out_q[$];

    int pass_cnt = 0;
    int total = 0;
    int underflow = 0;
    int viol = 0;
    int cyc, rd_cnt, xfers, first_rd, first_xfer, last_xfer;
    bit gate_empty = 1'b0;
    bit stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fq.size() == 0) begin
                underflow++;
            end else begin
                fifo_dout <= fq[0];
                exp_q.push_back(fq[0]);
                void'(fq.pop_front());
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    task automatic clear_stats();
        cyc = 0; rd_cnt = 0; xfers = 0; viol = 0;
        first_rd = -1; first_xfer = -1; last_xfer = -1;
        out_q.delete();
    endtask

    // One clock: starts and ends at a falling edge; inputs are set by the caller beforehand.
    task automatic step();
        fifo_empty = gate_empty | (fq.size() == 0);
        #1;
        if (fifo_rd_en && fifo_empty) viol++;
        if (stall_prev && (!m_valid || m_data !== data_prev)) viol++;
        stall_prev = m_valid && !m_ready;
        data_prev  = m_data;
        if (fifo_rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && m_ready) begin
            xfers++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            out_q.push_back(m_data);
            chk("xfer_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("stream_order", int'(m_data), int'(exp_q.pop_front()));
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_en", int'(fifo_rd_en), 0);
`ifdef FIFO_RD_STATS_EN
        chk("rst_xfer_count", int'(xfer_count), 0);
`endif
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int b;
        enable = 1'b0;
        m_ready = 1'b1;
        gate_empty = 1'b0;
        b = 0;
        while (busy && b < 20) begin
            step();
            b++;
        end
        chk("drain_idle", int'(busy), 0);
    endtask

    typedef struct {
        int n_words;
        int ready_pct;
        bit toggle;
        int exp_deliv;
        int exp_left;
    } vec_t;

    vec_t vt[5];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int budget, rd_at_drop;
        vt[0] = '{3, 100, 1'b0, 3, 0};
        vt[1] = '{12, 50, 1'b0, 12, 0};
        vt[2] = '{10, 100, 1'b1, 10, 0};
        vt[3] = '{20, 25, 1'b1, 20, 0};
        vt[4] = '{1, 10, 1'b0, 1, 0};

        @(negedge clk);
        do_reset();
        clear_stats();
        repeat (2) step();
        chk("idle_no_busy", int'(busy), 0);

        // Preloaded 0x11..0x18 at full throughput.
        clear_stats();
        for (int k = 0; k < 8; k++) fq.push_back(DW'(8'h11 + k));
        enable = 1'b1; m_ready = 1'b1; budget = 0;
        while (xfers < 8 && budget < 40) begin step(); budget++; end
        chk("burst_count", xfers, 8);
        chk("first_latency", first_xfer - first_rd, 2);
        chk("burst_span", last_xfer - first_xfer, 7);
        for (int j = 0; j < 8 && j < out_q.size(); j++) chk("burst_word", int'(out_q[j]), 8'h11 + j);
        drain();

        // Sink stalled for 5 cycles with 4 words queued.
        clear_stats();
        for (int k = 0; k < 4; k++) fq.push_back(DW'(8'h21 + k));
        enable = 1'b1; m_ready = 1'b0;
        repeat (5) step();
        chk("stall_reads", rd_cnt, 2);
        chk("stall_occ", int'(dut.occ), 2);
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_head", int'(m_data), 8'h21);
        m_ready = 1'b1; budget = 0;
        while (xfers < 4 && budget < 30) begin step(); budget++; end
        chk("stall_deliv", xfers, 4);
        for (int j = 0; j < 4 && j < out_q.size(); j++) chk("stall_word", int'(out_q[j]), 8'h21 + j);
        chk("stall_hold", viol, 0);
        drain();

        // enable dropped mid-stream of 6 words.
        clear_stats();
        for (int k = 0; k < 6; k++) fq.push_back(DW'(8'h31 + k));
        enable = 1'b1; m_ready = 1'b1;
        repeat (3) step();
        enable = 1'b0;
        step();
        rd_at_drop = rd_cnt;
        repeat (10) step();
        chk("drop_no_reads", rd_cnt, rd_at_drop);
        chk("drop_reads", rd_at_drop, 3);
        chk("drop_deliv", xfers, rd_at_drop);
        chk("drop_busy", int'(busy), 0);
        chk("drop_left", fq.size(), 6 - rd_at_drop);
        for (int j = 0; j < out_q.size(); j++) chk("drop_word", int'(out_q[j]), 8'h31 + j);
        fq.delete();

        // Randomized scenarios against the in-order scoreboard.
        for (int i = 0; i < 5; i++) begin
            clear_stats();
            for (int k = 0; k < vt[i].n_words; k++) fq.push_back(DW'($urandom));
            enable = 1'b1; budget = 0;
            while (xfers < vt[i].n_words && budget < 600) begin
                m_ready = ($urandom_range(0, 99) < vt[i].ready_pct);
                if (vt[i].toggle) gate_empty = ~gate_empty;
                step();
                budget++;
            end
            drain();
            chk("vec_deliv", xfers, vt[i].exp_deliv);
            chk("vec_left", fq.size(), vt[i].exp_left);
            chk("vec_pending", exp_q.size(), 0);
            chk("vec_protocol", viol, 0);
        end

        // Reset with a full buffer, then with a read in flight; stale data must not reappear.
        clear_stats();
        for (int k = 0; k < 4; k++) fq.push_back(DW'(8'h41 + k));
        enable = 1'b1; m_ready = 1'b0;
        repeat (4) step();
        chk("prerst_occ", int'(dut.occ), 2);
        m_ready = 1'b1;
        step();
        chk("prerst_infl", int'(dut.infl), 1);
        enable = 1'b0;
        do_reset();
        clear_stats();
        repeat (4) step();
        chk("postrst_quiet", xfers, 0);
        chk("postrst_valid", int'(m_valid), 0);
        fq.push_back(8'h45);
        fq.push_back(8'h46);
        enable = 1'b1; budget = 0;
        while (xfers < 3 && budget < 30) begin step(); budget++; end
        chk("postrst_deliv", xfers, 3);
        for (int j = 0; j < 3 && j < out_q.size(); j++) chk("postrst_word", int'(out_q[j]), 8'h44 + j);
        drain();
        chk("no_underflow", underflow, 0);

`ifdef FIFO_RD_STATS_EN
        do_reset();
        clear_stats();
        for (int k = 0; k < 17; k++) fq.push_back(DW'(k));
        enable = 1'b1; m_ready = 1'b1; budget = 0;
        while (xfers < 17 && budget < 60) begin step(); budget++; end
        chk("stats_xfers", xfers, 17);
        chk("stats_wrap", int'(xfer_count), 17 % 16);
        drain();
        chk("stats_hold", int'(xfer_count), 17 % 16);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
